// File: rtl/split_n_if.sv
// Bundle of channels around split_n: token input L, destination select, the
// per-output R channels and the illegal-select status.
interface split_n_if #(
  parameter int WIDTH = 2,
  parameter int NOUT  = 2
);
  // Valid/ready: a token moves on a rising edge where valid and ready are both
  // high. The producer holds data stable while valid=1 and ready=0.
  logic [WIDTH-1:0]      l_data;
  logic                  l_valid;
  logic                  l_ready;
  logic [NOUT-1:0]       sel;
  logic                  sel_valid;
  logic                  sel_ready;
  logic [NOUT*WIDTH-1:0] r_data;
  logic [NOUT-1:0]       r_valid;
  logic [NOUT-1:0]       r_ready;
  logic                  sel_err;
  logic [7:0]            err_count;

  modport slave (
    input  l_data, l_valid, sel, sel_valid, r_ready,
    output l_ready, sel_ready, r_data, r_valid, sel_err, err_count
  );

  modport master (
    output l_data, l_valid, sel, sel_valid, r_ready,
    input  l_ready, sel_ready, r_data, r_valid, sel_err, err_count
  );
endinterface

// File: rtl/split_n.sv
// N-way token split with one FIFO per output. L and select are consumed
// together; legal tokens go to every selected output atomically, illegal ones are counted.
module split_n #(
  parameter int WIDTH     = 2,
  parameter int NOUT      = 2,
  parameter int DEPTH     = 2,
  parameter int MULTICAST = 0
) (
  input  logic     CLK,
  input  logic     RESET_N,
  split_n_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            r_run;
  logic            r_sel_err;
  logic [7:0]      r_err_count;
  logic [NOUT-1:0] w_space;
  logic            w_multi;
  logic            w_illegal;
  logic            w_fire;

  assign w_multi   = |(s.sel & (s.sel - NOUT'(1)));
  assign w_illegal = (s.sel == '0) | ((MULTICAST == 0) & w_multi);
  // Space only from registered counts, so r_ready never reaches l_ready.
  assign w_fire    = r_run & s.l_valid & s.sel_valid & (w_illegal | (&(w_space | ~s.sel)));

  assign s.l_ready   = w_fire;
  assign s.sel_ready = w_fire;
  assign s.sel_err   = r_sel_err;
  assign s.err_count = r_err_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_run       <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_run     <= 1'b1;
      r_sel_err <= w_fire & w_illegal;
      if (w_fire && w_illegal && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NOUT; i++) begin : g_out
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_space[i] = (r_count < CW'(DEPTH));
    assign w_push     = w_fire & ~w_illegal & s.sel[i];
    assign w_pop      = (r_count != '0) & s.r_ready[i];

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_mem[k] <= '0;
        end
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= s.l_data;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
      end
    end

    assign s.r_valid[i]                = (r_count != '0);
    assign s.r_data[i*WIDTH +: WIDTH]  = r_mem[r_rd_ptr];
  end
endmodule

// File: tb/tb_split_n.sv
// Directed bench for split_n: a unicast 2-output instance driven from a vector
// table, and a 4-output multicast instance driven by hand sequences.
module tb_split_n;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  split_n_if #(.WIDTH(2), .NOUT(2)) b0();
  split_n_if #(.WIDTH(2), .NOUT(4)) b1();

  split_n #(.WIDTH(2), .NOUT(2), .DEPTH(2), .MULTICAST(0)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .s(b0)
  );
  split_n #(.WIDTH(2), .NOUT(4), .DEPTH(2), .MULTICAST(1)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .s(b1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       lv;
    logic       sv;
    logic [1:0] d;
    logic [1:0] sel;
    logic [1:0] rr;
    logic       fire;
    logic [1:0] rv;
    logic [3:0] rd;
    logic       err;
    logic [7:0] errc;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Only slices of outputs holding a token carry meaningful data.
  function automatic logic [31:0] vmask(input logic [31:0] d, input logic [7:0] v);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (v[i]) m[i*2 +: 2] = 2'b11;
    return d & m;
  endfunction

  function automatic vec_t mk(input logic lv, input logic sv, input logic [1:0] d,
                              input logic [1:0] sel, input logic [1:0] rr, input logic fire,
                              input logic [1:0] rv, input logic [3:0] rd, input logic err,
                              input logic [7:0] errc);
    vec_t v;
    v.lv = lv; v.sv = sv; v.d = d; v.sel = sel; v.rr = rr;
    v.fire = fire; v.rv = rv; v.rd = rd; v.err = err; v.errc = errc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic lv, input logic sv, input logic [1:0] d,
                        input logic [1:0] sel, input logic [1:0] rr);
    b0.l_valid = lv; b0.sel_valid = sv; b0.l_data = d; b0.sel = sel; b0.r_ready = rr;
  endtask

  task automatic drive1(input logic lv, input logic sv, input logic [1:0] d,
                        input logic [3:0] sel, input logic [3:0] rr);
    b1.l_valid = lv; b1.sel_valid = sv; b1.l_data = d; b1.sel = sel; b1.r_ready = rr;
  endtask

  initial begin
    drive0(1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
    drive1(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

    //             lv    sv    d      sel    rr     fire  rv     rd        err   errc
    vq.push_back(mk(1'b1, 1'b1, 2'b01, 2'b01, 2'b11, 1'b1, 2'b01, 4'b0001, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 2'b10, 2'b10, 2'b11, 1'b1, 2'b10, 4'b1000, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b0, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 4'b0000, 1'b0, 8'd0));
    vq.push_back(mk(1'b0, 1'b1, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 4'b0000, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 1'b1, 2'b00, 4'b0000, 1'b1, 8'd1));
    vq.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 2'b00, 4'b0000, 1'b1, 8'd2));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 4'b0000, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b1, 2'b01, 4'b0001, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1, 2'b01, 4'b0001, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, 2'b10, 1'b0, 2'b01, 4'b0001, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, 2'b11, 1'b0, 2'b01, 4'b0010, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, 2'b10, 1'b1, 2'b01, 4'b0010, 1'b0, 8'd2));
    vq.push_back(mk(1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 1'b1, 2'b11, 4'b1010, 1'b0, 8'd2));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 4'b0011, 1'b0, 8'd2));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 4'b0000, 1'b0, 8'd2));

    // Reset values while held in reset.
    #1;
    chk("rst r_valid", b0.r_valid, 2'b00);
    chk("rst r_data", b0.r_data, 4'h0);
    chk("rst l_ready", b0.l_ready, 1'b0);
    chk("rst sel_ready", b0.sel_ready, 1'b0);
    chk("rst sel_err", b0.sel_err, 1'b0);
    chk("rst err_count", b0.err_count, 8'd0);
    chk("rst mc r_valid", b1.r_valid, 4'b0000);

    // Release between edges: the first fire lands on the 2nd rising edge.
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive0(1'b1, 1'b1, 2'b01, 2'b01, 2'b11);
    #1;
    chk("release l_ready before edge1", b0.l_ready, 1'b0);
    tick();
    chk("release l_ready after edge1", b0.l_ready, 1'b1);
    chk("release r_valid after edge1", b0.r_valid, 2'b00);
    tick();
    chk("release r_valid after edge2", b0.r_valid, 2'b01);
    chk("release r_data after edge2", vmask(b0.r_data, 8'h01), 4'b0001);
    drive0(1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
    tick();
    tick();

    foreach (vq[k]) begin
      drive0(vq[k].lv, vq[k].sv, vq[k].d, vq[k].sel, vq[k].rr);
      #1;
      chk($sformatf("v%0d l_ready", k), b0.l_ready, vq[k].fire);
      chk($sformatf("v%0d sel_ready", k), b0.sel_ready, vq[k].fire);
      tick();
      chk($sformatf("v%0d r_valid", k), b0.r_valid, vq[k].rv);
      chk($sformatf("v%0d r_data", k), vmask(b0.r_data, 8'(vq[k].rv)), vq[k].rd);
      chk($sformatf("v%0d sel_err", k), b0.sel_err, vq[k].err);
      chk($sformatf("v%0d err_count", k), b0.err_count, vq[k].errc);
    end

    // Asynchronous reset with two tokens buffered in FIFO[0].
    drive0(1'b1, 1'b1, 2'b11, 2'b01, 2'b10);
    tick();
    b0.l_data = 2'b01;
    tick();
    drive0(1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
    chk("prereset r_valid", b0.r_valid, 2'b01);
    #2;
    rst_n = 1'b0;
    drive0(1'b1, 1'b1, 2'b10, 2'b01, 2'b10);
    #1;
    chk("async rst r_valid", b0.r_valid, 2'b00);
    chk("async rst err_count", b0.err_count, 8'd0);
    chk("async rst r_data", b0.r_data, 4'h0);
    chk("async rst l_ready", b0.l_ready, 1'b0);
    tick();
    chk("in rst l_ready", b0.l_ready, 1'b0);
    drive0(1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post rst fifo0 empty", b0.r_valid, 2'b00);

    // Illegal selects saturate the error counter.
    drive0(1'b1, 1'b1, 2'b11, 2'b11, 2'b11);
    #1;
    chk("illegal l_ready", b0.l_ready, 1'b1);
    repeat (254) tick();
    chk("err_count 254", b0.err_count, 8'd254);
    chk("sel_err held", b0.sel_err, 1'b1);
    tick();
    chk("err_count 255", b0.err_count, 8'd255);
    repeat (45) tick();
    chk("err_count sat 300", b0.err_count, 8'd255);
    chk("illegal no r_valid", b0.r_valid, 2'b00);
    drive0(1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
    tick();
    chk("sel_err drop", b0.sel_err, 1'b0);
    chk("err_count stays", b0.err_count, 8'd255);

    // Multicast on the 4-output instance.
    drive1(1'b1, 1'b1, 2'b11, 4'b1011, 4'b0000);
    #1;
    chk("mc fire", b1.l_ready, 1'b1);
    tick();
    chk("mc r_valid", b1.r_valid, 4'b1011);
    chk("mc r_data", vmask(b1.r_data, 8'hB), 8'hCF);
    drive1(1'b1, 1'b1, 2'b01, 4'b0010, 4'b0000);
    #1;
    chk("mc fill r1 fire", b1.l_ready, 1'b1);
    tick();
    chk("mc fill r1 r_valid", b1.r_valid, 4'b1011);
    chk("mc fill r1 r_data", vmask(b1.r_data, 8'hB), 8'hCF);
    drive1(1'b1, 1'b1, 2'b10, 4'b1011, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("mc blocked fire c%0d", c), b1.l_ready, 1'b0);
      tick();
      chk($sformatf("mc blocked r_valid c%0d", c), b1.r_valid, 4'b1011);
      chk($sformatf("mc blocked r_data c%0d", c), vmask(b1.r_data, 8'hB), 8'hCF);
    end
    b1.r_ready = 4'b0010;
    #1;
    chk("mc no bypass", b1.l_ready, 1'b0);
    tick();
    chk("mc r1 popped r_data", vmask(b1.r_data, 8'hB), 8'hC7);
    b1.r_ready = 4'b0000;
    #1;
    chk("mc unblocked fire", b1.l_ready, 1'b1);
    tick();
    drive1(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0001);
    tick();
    chk("mc r0 second r_valid", b1.r_valid, 4'b1011);
    chk("mc r0 second r_data", vmask(b1.r_data, 8'hB), 8'hC6);
    tick();
    chk("mc r0 drained r_valid", b1.r_valid, 4'b1010);
    chk("mc r0 drained r_data", vmask(b1.r_data, 8'hA), 8'hC4);
    b1.r_ready = 4'b1111;
    tick();
    chk("mc tail r_valid", b1.r_valid, 4'b1010);
    chk("mc tail r_data", vmask(b1.r_data, 8'hA), 8'h88);
    tick();
    chk("mc empty r_valid", b1.r_valid, 4'b0000);
    drive1(1'b1, 1'b1, 2'b01, 4'b0000, 4'b1111);
    #1;
    chk("mc zero sel fire", b1.l_ready, 1'b1);
    tick();
    drive1(1'b0, 1'b0, 2'b00, 4'b0000, 4'b1111);
    chk("mc zero sel_err", b1.sel_err, 1'b1);
    chk("mc zero err_count", b1.err_count, 8'd1);
    chk("mc zero r_valid", b1.r_valid, 4'b0000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/split_n.md
Name: split_n

Overview:
- Clocked, parametrised successor to the two-way PCHB split used in the router datapath.
- Steers each token on input channel L to one output channel R[i], or to several when multicast is enabled. The destination comes from a one-hot select channel.
- Generalises the split in data width, output count and buffering: each output has its own FIFO.
- Adds multicast mode and illegal-select detection, which the two-way split does not have.
- Sits between the route-compute stage and the output-port arbiters.

Parameters:
- WIDTH, 2, data bits per token.
- NOUT, 2, number of output channels (2..8).
- DEPTH, 2, entries per output FIFO (power of two, >=2).
- MULTICAST, 0, 1 allows multiple select bits set (token replicated to every selected output).

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- l_data  input  WIDTH  input token data.
- l_valid  input  1  input token present.
- l_ready  output  1  input token consumed this cycle.
- sel  input  NOUT  one-hot destination select (multi-hot if MULTICAST=1).
- sel_valid  input  1  select token present.
- sel_ready  output  1  select token consumed this cycle.
- r_data  output  NOUT*WIDTH  output data; slice i = [i*WIDTH +: WIDTH].
- r_valid  output  NOUT  per-output token present.
- r_ready  input  NOUT  per-output consumer accepts.
- sel_err  output  1  one-cycle pulse: illegal select consumed.
- err_count  output  8  saturating count of illegal selects.

Behaviour:
- Reset (RESET_N=0, asynchronous): all FIFOs emptied, r_valid=0, r_data=0, l_ready=0, sel_ready=0, sel_err=0, err_count=0. Reset mid-transfer discards all buffered tokens. Release is synchronised to CLK; the first fire is possible on the 2nd rising edge after deassertion.
- Legal select: sel != 0, and sel is one-hot when MULTICAST=0.
- space[i] = (count[i] < DEPTH), computed from registered counts only. There is no same-cycle bypass when full, even if r_ready[i]=1.
- fire = l_valid & sel_valid & (illegal | all space[i] for every i with sel[i]=1).
- l_ready = sel_ready = fire. L and select are always consumed together, never one without the other.
- Legal fire: l_data is pushed into FIFO i for every set sel[i], atomically. Either all selected outputs accept or none do.
- Illegal fire: token dropped, no FIFO pushed, sel_err=1 for one cycle, err_count increments and saturates at 255.
- Latency: r_valid[i] rises the cycle after the push edge; r_data[i] is the FIFO head, registered.
- Output handshake: pop on r_valid[i] & r_ready[i]. r_data and r_valid are held stable while r_valid=1 and r_ready=0.
- Push and pop on the same output in the same cycle: count unchanged, FIFO order preserved.
- Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- Outputs are independent: a stalled R[j] blocks only tokens that select j. Head-of-line blocking at L is accepted by design.
- l_valid without sel_valid, or sel_valid without l_valid: no fire, nothing consumed, inputs held by the producer.
- l_ready/sel_ready are combinational from the inputs and registered counts. There are no combinational paths from r_ready to l_ready within the same cycle.

Test Plan:
- Reset: RESET_N=0 mid-operation with FIFO[0] holding 2 tokens -> r_valid=00, err_count=0 immediately; after release, FIFO[0] is empty.
- Unicast, NOUT=2: l_data=01, sel=01, both valids=1, r_ready=11 -> fire that cycle; next cycle r_valid=01, r_data[1:0]=01. Then l_data=10, sel=10 -> r_valid=10, r_data[3:2]=10.
- Backpressure, DEPTH=2: r_ready[0]=0, send 3 tokens with sel=01 -> first two fire; third holds l_ready=0. Raise r_ready[0] -> tokens drain in order; third fires the cycle after the count drops to 1.
- Independence: R0 full and stalled, then send sel=10 -> fires immediately and R1 receives the token while R0 stays unchanged.
- Illegal select, MULTICAST=0: sel=11, then sel=00 -> both consumed, sel_err pulses twice, err_count=2, no r_valid change. Force 300 illegal selects -> err_count=255.
- Multicast, MULTICAST=1, NOUT=4: sel=1011, l_data=11 -> R0, R1, R3 each get 11 next cycle. With R1 full, the token is held and no output receives it until R1 has space.
